eth_rx_frame_buf: RTL and testbench

//  Frame-buffer controller behind the RMII receive datapath. It writes formed bytes (Byte_Rdy/Byte) of the frame
//  in flight into a circular byte RAM, then commits or discards them from Rx_En framing and Crc_Valid.

---
 rtl/eth_pkg.sv | 15 +
 rtl/eth_rx_len_fifo.sv | 65 ++++++
 rtl/eth_rx_frame_buf.sv | 210 +++++++++++++++++++++
 tb/tb_eth_rx_frame_buf.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet receive-path definitions: receive FSM encoding and frame-size limits.
package eth_pkg;

  localparam int unsigned ETH_MIN_LEN = 64;
  localparam int unsigned ETH_MAX_LEN = 1518;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    TAIL  = 3'd2,
    CHECK = 3'd3,
    DROP  = 3'd4
  } rx_state_t;

endpackage

// File: rtl/eth_rx_len_fifo.sv
// Committed-frame length FIFO with a registered first-word-fall-through head.
module eth_rx_len_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 11
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic             o_full,
  output logic [WIDTH-1:0] o_head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_valid;
  logic             r_full;
  logic [WIDTH-1:0] r_head;

  logic             w_push_ok;
  logic             w_pop_ok;
  logic [AW-1:0]    w_rd_next;
  logic [AW:0]      w_count_next;
  logic [WIDTH-1:0] w_head_next;

  assign w_push_ok    = i_push & ~r_full;
  assign w_pop_ok     = i_pop & r_valid;
  assign w_rd_next    = w_pop_ok ? r_rd_ptr + AW'(1) : r_rd_ptr;
  assign w_count_next = r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
  // The new head is the word being pushed this cycle when nothing older remains.
  assign w_head_next  = (w_push_ok && (w_rd_next == r_wr_ptr)) ? i_data : r_mem[w_rd_next];

  always_ff @(posedge Clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_full   <= 1'b0;
      r_head   <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      r_valid  <= (w_count_next != '0);
      r_full   <= (w_count_next == (AW+1)'(DEPTH));
      r_head   <= (w_count_next != '0) ? w_head_next : '0;
    end
  end

  assign o_valid = r_valid;
  assign o_full  = r_full;
  assign o_head  = r_head;

endmodule

// File: rtl/eth_rx_frame_buf.sv
// RMII receive frame buffer: stores bytes of the frame in flight in a circular RAM,
// commits or discards them at frame end, and serves committed frames to a byte reader.
module eth_rx_frame_buf
  import eth_pkg::*;
#(
  parameter int unsigned DEPTH     = 2048,
  parameter int unsigned LEN_DEPTH = 8,
  parameter int unsigned MIN_LEN   = ETH_MIN_LEN,
  parameter int unsigned MAX_LEN   = ETH_MAX_LEN,
  parameter int unsigned TAIL_CYC  = 2,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Rx_En,
  input  logic             Byte_Rdy,
  input  logic [7:0]       Byte,
  input  logic             Crc_Valid,
  output logic             Frm_Valid,
  output logic [LEN_W-1:0] Frm_Len,
  input  logic             Rd_En,
  output logic [7:0]       Rd_Data,
  output logic             Rd_Valid,
  output logic             Rd_Last,
  output logic [CNT_W-1:0] Good_Cnt,
  output logic [CNT_W-1:0] Bad_Cnt,
  output logic [CNT_W-1:0] Drop_Cnt
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned TAIL_W = (TAIL_CYC > 1) ? $clog2(TAIL_CYC) : 1;

  rx_state_t        r_state;
  rx_state_t        w_state_next;
  logic             r_rx_en_d1;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_commit_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LEN_W-1:0] r_len;
  logic [TAIL_W-1:0] r_tail;
  logic [LEN_W-1:0] r_rd_cnt;
  logic [7:0]       r_ram [DEPTH];
  logic [7:0]       r_rd_data;
  logic             r_rd_valid;
  logic             r_rd_last;
  logic [CNT_W-1:0] r_good_cnt;
  logic [CNT_W-1:0] r_bad_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_wr_en;
  logic             w_rollback;
  logic             w_commit;
  logic             w_good_inc;
  logic             w_bad_inc;
  logic             w_drop_inc;
  logic             w_len_clr;
  logic             w_tail_clr;
  logic             w_tail_inc;
  logic             w_rise;
  logic             w_over;
  logic [PTR_W-1:0] w_used;
  logic             w_fifo_valid;
  logic             w_fifo_full;
  logic [LEN_W-1:0] w_fifo_head;
  logic             w_rd_acc;
  logic             w_rd_last;

  assign w_rise   = Rx_En & ~r_rx_en_d1;
  assign w_used   = r_wr_ptr - r_rd_ptr;
  // Full check uses the pre-read occupancy, so a same-cycle read never rescues a byte.
  assign w_over   = (w_used == PTR_W'(DEPTH)) || (r_len == LEN_W'(MAX_LEN));
  assign w_rd_acc = Rd_En & w_fifo_valid;
  assign w_rd_last = w_rd_acc & (r_rd_cnt == (w_fifo_head - LEN_W'(1)));

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_wr_en      = 1'b0;
    w_rollback   = 1'b0;
    w_commit     = 1'b0;
    w_good_inc   = 1'b0;
    w_bad_inc    = 1'b0;
    w_drop_inc   = 1'b0;
    w_len_clr    = 1'b0;
    w_tail_clr   = 1'b0;
    w_tail_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_len_clr = 1'b1;
          if (w_fifo_full) begin
            w_drop_inc   = 1'b1;
            w_state_next = DROP;
          end else begin
            w_state_next = RECV;
          end
        end
      end
      RECV: begin
        if (Byte_Rdy && w_over) begin
          w_rollback   = 1'b1;
          w_drop_inc   = 1'b1;
          w_state_next = DROP;
        end else begin
          w_wr_en = Byte_Rdy;
          if (!Rx_En) begin
            w_tail_clr   = 1'b1;
            w_state_next = TAIL;
          end
        end
      end
      TAIL: begin
        if (Byte_Rdy && w_over) begin
          w_rollback   = 1'b1;
          w_drop_inc   = 1'b1;
          w_state_next = DROP;
        end else begin
          w_wr_en    = Byte_Rdy;
          w_tail_inc = 1'b1;
          if (r_tail == TAIL_W'(TAIL_CYC - 1)) w_state_next = CHECK;
        end
      end
      CHECK: begin
        if (Crc_Valid && (r_len >= LEN_W'(MIN_LEN))) begin
          w_commit   = 1'b1;
          w_good_inc = 1'b1;
        end else begin
          w_rollback = 1'b1;
          w_bad_inc  = 1'b1;
        end
        w_state_next = IDLE;
      end
      DROP: begin
        if (!Rx_En) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (w_wr_en) r_ram[r_wr_ptr[ADDR_W-1:0]] <= Byte;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_rx_en_d1   <= 1'b1;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_len        <= '0;
      r_tail       <= '0;
      r_rd_cnt     <= '0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_last    <= 1'b0;
      r_good_cnt   <= '0;
      r_bad_cnt    <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_rx_en_d1 <= Rx_En;
      if (w_rollback)   r_wr_ptr <= r_commit_ptr;
      else if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_commit) r_commit_ptr <= r_wr_ptr;
      if (w_len_clr)    r_len <= '0;
      else if (w_wr_en) r_len <= r_len + LEN_W'(1);
      if (w_tail_clr)      r_tail <= '0;
      else if (w_tail_inc) r_tail <= r_tail + TAIL_W'(1);
      r_rd_valid <= w_rd_acc;
      r_rd_last  <= w_rd_last;
      if (w_rd_acc) begin
        r_rd_data <= r_ram[r_rd_ptr[ADDR_W-1:0]];
        r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
        r_rd_cnt  <= w_rd_last ? '0 : r_rd_cnt + LEN_W'(1);
      end
      if (w_good_inc && (r_good_cnt != '1)) r_good_cnt <= r_good_cnt + CNT_W'(1);
      if (w_bad_inc  && (r_bad_cnt  != '1)) r_bad_cnt  <= r_bad_cnt  + CNT_W'(1);
      if (w_drop_inc && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  eth_rx_len_fifo #(
    .DEPTH (LEN_DEPTH),
    .WIDTH (LEN_W)
  ) u_len_fifo (
    .Clk     (Clk),
    .Rst     (Rst),
    .i_push  (w_commit),
    .i_data  (r_len),
    .i_pop   (w_rd_last),
    .o_valid (w_fifo_valid),
    .o_full  (w_fifo_full),
    .o_head  (w_fifo_head)
  );

  assign Frm_Valid = w_fifo_valid;
  assign Frm_Len   = w_fifo_head;
  assign Rd_Data   = r_rd_data;
  assign Rd_Valid  = r_rd_valid;
  assign Rd_Last   = r_rd_last;
  assign Good_Cnt  = r_good_cnt;
  assign Bad_Cnt   = r_bad_cnt;
  assign Drop_Cnt  = r_drop_cnt;

endmodule

// File: tb/tb_eth_rx_frame_buf.sv
// Bench for eth_rx_frame_buf: random frames scored against a frame-level reference model.
module tb_eth_rx_frame_buf;

  localparam int unsigned LEN_W     = 11;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned LEN_DEPTH = 8;
  localparam int unsigned MAX_LEN   = 1518;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       rx_en = 1'b0, byte_rdy = 1'b0, crc_valid = 1'b0, rd_en = 1'b0;
  logic [7:0] byte_d = 8'h00;

  logic a_rx_en, a_byte_rdy, a_crc, a_rd_en, b_rx_en, b_byte_rdy, b_crc, b_rd_en;
  logic a_frm_valid, a_rd_valid, a_rd_last, b_frm_valid, b_rd_valid, b_rd_last;
  logic [LEN_W-1:0] a_frm_len, b_frm_len;
  logic [7:0]       a_rd_data, b_rd_data;
  logic [CNT_W-1:0] a_good, a_bad, a_drop, b_good, b_bad, b_drop;

  assign a_rx_en    = ~sel & rx_en;
  assign a_byte_rdy = ~sel & byte_rdy;
  assign a_crc      = ~sel & crc_valid;
  assign a_rd_en    = ~sel & rd_en;
  assign b_rx_en    = sel & rx_en;
  assign b_byte_rdy = sel & byte_rdy;
  assign b_crc      = sel & crc_valid;
  assign b_rd_en    = sel & rd_en;

  eth_rx_frame_buf dut_a (
    .Clk(clk), .Rst(rst), .Rx_En(a_rx_en), .Byte_Rdy(a_byte_rdy), .Byte(byte_d),
    .Crc_Valid(a_crc), .Frm_Valid(a_frm_valid), .Frm_Len(a_frm_len), .Rd_En(a_rd_en),
    .Rd_Data(a_rd_data), .Rd_Valid(a_rd_valid), .Rd_Last(a_rd_last),
    .Good_Cnt(a_good), .Bad_Cnt(a_bad), .Drop_Cnt(a_drop)
  );

  eth_rx_frame_buf #(.DEPTH(128)) dut_b (
    .Clk(clk), .Rst(rst), .Rx_En(b_rx_en), .Byte_Rdy(b_byte_rdy), .Byte(byte_d),
    .Crc_Valid(b_crc), .Frm_Valid(b_frm_valid), .Frm_Len(b_frm_len), .Rd_En(b_rd_en),
    .Rd_Data(b_rd_data), .Rd_Valid(b_rd_valid), .Rd_Last(b_rd_last),
    .Good_Cnt(b_good), .Bad_Cnt(b_bad), .Drop_Cnt(b_drop)
  );

  logic             obs_frm_valid, obs_rd_valid, obs_rd_last;
  logic [LEN_W-1:0] obs_frm_len;
  logic [7:0]       obs_rd_data;
  logic [CNT_W-1:0] obs_good, obs_bad, obs_drop;

  assign obs_frm_valid = sel ? b_frm_valid : a_frm_valid;
  assign obs_frm_len   = sel ? b_frm_len   : a_frm_len;
  assign obs_rd_valid  = sel ? b_rd_valid  : a_rd_valid;
  assign obs_rd_last   = sel ? b_rd_last   : a_rd_last;
  assign obs_rd_data   = sel ? b_rd_data   : a_rd_data;
  assign obs_good      = sel ? b_good      : a_good;
  assign obs_bad       = sel ? b_bad       : a_bad;
  assign obs_drop      = sel ? b_drop      : a_drop;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: committed-but-unread bytes, committed frame lengths, counters.
  logic [7:0] m_bytes[$];
  int         m_lens[$];
  int         m_depth;
  int         m_good, m_bad, m_drop;

  task automatic do_reset(input logic s);
    sel = s; rst = 1'b1; rx_en = 1'b0; byte_rdy = 1'b0; crc_valid = 1'b0; rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    m_bytes.delete(); m_lens.delete();
    m_good = 0; m_bad = 0; m_drop = 0;
    m_depth = s ? 128 : 2048;
    @(posedge clk); #1;
  endtask

  // Drives one frame; the model decides each byte's fate from occupancy and length limits.
  task automatic send_frame(input int len, input logic crc, input logic tail_mode);
    logic [7:0] cur[$];
    logic [7:0] b;
    bit dropped;
    dropped = (m_lens.size() == LEN_DEPTH);
    if (dropped) m_drop++;
    @(posedge clk); #1 rx_en = 1'b1; crc_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1 byte_rdy = 1'b0; end
      if (tail_mode && i == len - 1) begin
        @(posedge clk); #1 byte_rdy = 1'b0; rx_en = 1'b0; crc_valid = crc;
      end
      @(posedge clk); #1 byte_rdy = 1'b1; byte_d = b;
      if (!dropped) begin
        if ((m_bytes.size() + cur.size() == m_depth) || (cur.size() == MAX_LEN)) begin
          dropped = 1'b1; m_drop++;
        end else begin
          cur.push_back(b);
        end
      end
    end
    @(posedge clk); #1 byte_rdy = 1'b0; rx_en = 1'b0; crc_valid = crc;
    repeat (6) begin @(posedge clk); #1; end
    crc_valid = 1'b0;
    if (!dropped) begin
      if (crc && cur.size() >= 64) begin
        foreach (cur[k]) m_bytes.push_back(cur[k]);
        m_lens.push_back(cur.size());
        m_good++;
      end else begin
        m_bad++;
      end
    end
  endtask

  // Reads the head frame with random Rd_En gaps and scores every returned byte.
  task automatic read_frame();
    int len, issued, wait_cyc;
    logic [7:0] exp_b;
    logic exp_last;
    wait_cyc = 0;
    while (obs_frm_valid !== 1'b1 && wait_cyc < 100) begin @(posedge clk); #1; wait_cyc++; end
    vectors++;
    if (obs_frm_valid !== 1'b1 || m_lens.size() == 0) begin
      miscompares++;
      $display("FAIL frm_valid_wait: got %b required 1 (model frames %0d)", obs_frm_valid, m_lens.size());
      return;
    end
    len = m_lens[0];
    vectors++;
    if (obs_frm_len !== LEN_W'(len)) begin
      miscompares++;
      $display("FAIL frm_len: got %0d required %0d", obs_frm_len, len);
    end
    issued = 0;
    for (int cyc = 0; cyc < 8 * len + 20 && issued < len; cyc++) begin
      rd_en = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      vectors++;
      if (rd_en) begin
        exp_b = m_bytes.pop_front();
        exp_last = (issued == len - 1);
        issued++;
        if ({obs_rd_valid, obs_rd_last, obs_rd_data} !== {1'b1, exp_last, exp_b}) begin
          miscompares++;
          $display("FAIL rd_byte[%0d]: got valid=%b last=%b data=%02h required 1 %b %02h",
                   issued - 1, obs_rd_valid, obs_rd_last, obs_rd_data, exp_last, exp_b);
        end
      end else if (obs_rd_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rd_idle: got rd_valid=%b required 0", obs_rd_valid);
      end
    end
    rd_en = 1'b0;
    vectors++;
    if (issued != len) begin
      miscompares++;
      $display("FAIL rd_timeout: read %0d of %0d bytes", issued, len);
      for (int k = issued; k < len; k++) void'(m_bytes.pop_front());
    end
    void'(m_lens.pop_front());
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    vectors++;
    if ({obs_frm_valid, obs_frm_len, obs_rd_valid, obs_rd_last, obs_rd_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got fv=%b len=%0d rv=%b rl=%b rd=%02h required all 0",
               obs_frm_valid, obs_frm_len, obs_rd_valid, obs_rd_last, obs_rd_data);
    end
    vectors++;
    if ({obs_good, obs_bad, obs_drop} !== '0) begin
      miscompares++;
      $display("FAIL reset_counters: got %0d %0d %0d required 0 0 0", obs_good, obs_bad, obs_drop);
    end
    rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
    vectors++;
    if (obs_rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_when_empty: got rd_valid=%b required 0", obs_rd_valid);
    end
  endtask

  task automatic test_min_frame();
    do_reset(1'b0);
    send_frame(64, 1'b1, 1'b0);
    vectors++;
    if ({obs_frm_valid, obs_frm_len} !== {1'b1, LEN_W'(64)}) begin
      miscompares++;
      $display("FAIL min_frame_desc: got fv=%b len=%0d required 1 64", obs_frm_valid, obs_frm_len);
    end
    vectors++;
    if ({obs_good, obs_bad, obs_drop} !== {CNT_W'(m_good), CNT_W'(m_bad), CNT_W'(m_drop)}) begin
      miscompares++;
      $display("FAIL min_frame_cnt: got %0d %0d %0d required %0d %0d %0d",
               obs_good, obs_bad, obs_drop, m_good, m_bad, m_drop);
    end
    read_frame();
    vectors++;
    if (obs_frm_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL min_frame_drained: got fv=%b required 0", obs_frm_valid);
    end
  endtask

  task automatic test_bad_crc();
    do_reset(1'b0);
    send_frame(100, 1'b0, 1'b0);
    vectors++;
    if ({obs_frm_valid, obs_bad} !== {1'b0, CNT_W'(1)}) begin
      miscompares++;
      $display("FAIL bad_crc: got fv=%b bad=%0d required 0 1", obs_frm_valid, obs_bad);
    end
    send_frame(80, 1'b1, 1'b1);
    read_frame();
    vectors++;
    if ({obs_good, obs_bad, obs_drop} !== {CNT_W'(m_good), CNT_W'(m_bad), CNT_W'(m_drop)}) begin
      miscompares++;
      $display("FAIL bad_crc_cnt: got %0d %0d %0d required %0d %0d %0d",
               obs_good, obs_bad, obs_drop, m_good, m_bad, m_drop);
    end
  endtask

  task automatic test_runt();
    do_reset(1'b0);
    send_frame(40, 1'b1, 1'b1);
    send_frame(63, 1'b1, 1'b0);
    vectors++;
    if ({obs_frm_valid, obs_good, obs_bad} !== {1'b0, CNT_W'(0), CNT_W'(2)}) begin
      miscompares++;
      $display("FAIL runt: got fv=%b good=%0d bad=%0d required 0 0 2", obs_frm_valid, obs_good, obs_bad);
    end
  endtask

  task automatic test_ram_full();
    do_reset(1'b1);
    send_frame(100, 1'b1, 1'b0);
    send_frame(100, 1'b1, 1'b0);
    vectors++;
    if ({obs_good, obs_bad, obs_drop} !== {CNT_W'(1), CNT_W'(0), CNT_W'(1)}) begin
      miscompares++;
      $display("FAIL ram_full_cnt: got %0d %0d %0d required 1 0 1", obs_good, obs_bad, obs_drop);
    end
    read_frame();
    send_frame(90, 1'b1, 1'b1);
    read_frame();
    vectors++;
    if ({obs_good, obs_bad, obs_drop} !== {CNT_W'(m_good), CNT_W'(m_bad), CNT_W'(m_drop)}) begin
      miscompares++;
      $display("FAIL ram_full_after: got %0d %0d %0d required %0d %0d %0d",
               obs_good, obs_bad, obs_drop, m_good, m_bad, m_drop);
    end
  endtask

  task automatic test_oversize();
    do_reset(1'b0);
    send_frame(1600, 1'b1, 1'b0);
    vectors++;
    if ({obs_frm_valid, obs_good, obs_drop} !== {1'b0, CNT_W'(0), CNT_W'(1)}) begin
      miscompares++;
      $display("FAIL oversize: got fv=%b good=%0d drop=%0d required 0 0 1", obs_frm_valid, obs_good, obs_drop);
    end
    send_frame(MAX_LEN, 1'b1, 1'b1);
    send_frame(64, 1'b1, 1'b0);
    read_frame();
    read_frame();
    vectors++;
    if ({obs_good, obs_bad, obs_drop} !== {CNT_W'(m_good), CNT_W'(m_bad), CNT_W'(m_drop)}) begin
      miscompares++;
      $display("FAIL oversize_after: got %0d %0d %0d required %0d %0d %0d",
               obs_good, obs_bad, obs_drop, m_good, m_bad, m_drop);
    end
  endtask

  task automatic test_len_fifo_full();
    do_reset(1'b0);
    for (int i = 0; i < 9; i++) send_frame(64 + i, 1'b1, 1'($urandom_range(0, 1)));
    vectors++;
    if ({obs_good, obs_bad, obs_drop} !== {CNT_W'(8), CNT_W'(0), CNT_W'(1)}) begin
      miscompares++;
      $display("FAIL len_fifo_full: got %0d %0d %0d required 8 0 1", obs_good, obs_bad, obs_drop);
    end
    for (int i = 0; i < 9 && m_lens.size() > 0; i++) read_frame();
    vectors++;
    if (obs_frm_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL len_fifo_drained: got fv=%b required 0", obs_frm_valid);
    end
  endtask

  task automatic test_random();
    do_reset(1'b0);
    for (int f = 0; f < 12; f++) begin
      send_frame($urandom_range(20, 300), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      if (m_lens.size() > 0 && $urandom_range(0, 1) == 1) read_frame();
    end
    for (int i = 0; i < LEN_DEPTH + 1 && m_lens.size() > 0; i++) read_frame();
    vectors++;
    if ({obs_frm_valid, obs_good, obs_bad, obs_drop} !==
        {1'b0, CNT_W'(m_good), CNT_W'(m_bad), CNT_W'(m_drop)}) begin
      miscompares++;
      $display("FAIL random_final: got fv=%b %0d %0d %0d required 0 %0d %0d %0d",
               obs_frm_valid, obs_good, obs_bad, obs_drop, m_good, m_bad, m_drop);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0);
    send_frame(120, 1'b1, 1'b0);
    for (int r = 0; r < 3; r++) begin
      fork
        send_frame($urandom_range(64, 160), 1'b1, 1'($urandom_range(0, 1)));
        read_frame();
      join
    end
    for (int i = 0; i < 4 && m_lens.size() > 0; i++) read_frame();
    vectors++;
    if ({obs_frm_valid, obs_good, obs_bad, obs_drop} !==
        {1'b0, CNT_W'(m_good), CNT_W'(m_bad), CNT_W'(m_drop)}) begin
      miscompares++;
      $display("FAIL back_to_back: got fv=%b %0d %0d %0d required 0 %0d %0d %0d",
               obs_frm_valid, obs_good, obs_bad, obs_drop, m_good, m_bad, m_drop);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset(1'b0);
    send_frame(70, 1'b1, 1'b0);
    @(posedge clk); #1 rx_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 byte_rdy = 1'b1; byte_d = 8'($urandom);
      @(posedge clk); #1 byte_rdy = 1'b0;
    end
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1 byte_rdy = ~byte_rdy; end
    rst = 1'b0; byte_rdy = 1'b0;
    m_bytes.delete(); m_lens.delete();
    m_good = 0; m_bad = 0; m_drop = 0;
    vectors++;
    if ({obs_frm_valid, obs_frm_len, obs_rd_valid, obs_good, obs_bad, obs_drop} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got fv=%b len=%0d rv=%b cnt=%0d %0d %0d required all 0",
               obs_frm_valid, obs_frm_len, obs_rd_valid, obs_good, obs_bad, obs_drop);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1 byte_rdy = 1'b1; byte_d = 8'($urandom);
      @(posedge clk); #1 byte_rdy = 1'b0;
    end
    rx_en = 1'b0; crc_valid = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    crc_valid = 1'b0;
    vectors++;
    if ({obs_frm_valid, obs_good, obs_bad, obs_drop} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_ignored: got fv=%b cnt=%0d %0d %0d required 0 0 0 0",
               obs_frm_valid, obs_good, obs_bad, obs_drop);
    end
    send_frame(64, 1'b1, 1'b1);
    read_frame();
    vectors++;
    if ({obs_good, obs_bad, obs_drop} !== {CNT_W'(1), CNT_W'(0), CNT_W'(0)}) begin
      miscompares++;
      $display("FAIL mid_reset_next: got %0d %0d %0d required 1 0 0", obs_good, obs_bad, obs_drop);
    end
  endtask

  initial begin
    test_reset();
    test_min_frame();
    test_bad_crc();
    test_runt();
    test_ram_full();
    test_oversize();
    test_len_fifo_full();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
